rv32i_pipe_core: RTL and testbench

//  Minimal 5-stage in-order RV32I pipeline: IF, ID, EX, MEM, WB.

---
 rtl/rv32i_pipe_core.sv | 217 +++++++++++++++++++++
 tb/tb_rv32i_pipe_core.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_pipe_core.sv
// Minimal 5-stage in-order RV32I core (IF/ID/EX/MEM/WB) with internal ROM, register file and data RAM.
// No forwarding or interlocks; only the write-first register file bridges a distance-3 dependency.
module rv32i_pipe_core #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    REG_ADDR_WIDTH = 5,
    parameter int    IMEM_DEPTH     = 256,
    parameter int    DMEM_DEPTH     = 256,
    parameter string IMEM_INIT      = ""
) (
    input logic clk,
    input logic rst_n,
    input logic pc_we
);
    localparam int IAW  = $clog2(IMEM_DEPTH);
    localparam int DAW  = $clog2(DMEM_DEPTH);
    localparam int NREG = 2 ** REG_ADDR_WIDTH;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [6:0]  OP_R   = 7'b0110011;
    localparam logic [6:0]  OP_I   = 7'b0010011;
    localparam logic [6:0]  OP_LW  = 7'b0000011;
    localparam logic [6:0]  OP_SW  = 7'b0100011;
    localparam logic [6:0]  OP_LUI = 7'b0110111;

    logic [31:0]           imem        [0:IMEM_DEPTH-1];
    logic [DATA_WIDTH-1:0] registers   [0:NREG-1];
    logic [DATA_WIDTH-1:0] data_memory [0:DMEM_DEPTH-1];

    // ROM defaults to all NOPs; benches preload it hierarchically
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = NOP;
    end

    // ---------------- IF (depths are powers of two, so slicing gives the wrap) ----------------
    logic [DATA_WIDTH-1:0] pc;
    logic [31:0]           if_id_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            if_id_instr <= NOP;
        end else if (pc_we) begin
            pc          <= pc + DATA_WIDTH'(4);
            if_id_instr <= imem[pc[IAW+1:2]];
        end else begin
            if_id_instr <= NOP;
        end
    end

    // ---------------- ID ----------------
    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [REG_ADDR_WIDTH-1:0] rd, rs1, rs2;
    logic [DATA_WIDTH-1:0]     imm_i, imm_s, imm_u, rs1_val, rs2_val;
    logic                      mem_wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] mem_wb_rd;
    logic [DATA_WIDTH-1:0]     mem_wb_data;

    assign opcode = if_id_instr[6:0];
    assign funct3 = if_id_instr[14:12];
    assign rd     = if_id_instr[11:7];
    assign rs1    = if_id_instr[19:15];
    assign rs2    = if_id_instr[24:20];
    assign imm_i  = DATA_WIDTH'($signed(if_id_instr[31:20]));
    assign imm_s  = DATA_WIDTH'($signed({if_id_instr[31:25], if_id_instr[11:7]}));
    assign imm_u  = DATA_WIDTH'({if_id_instr[31:12], 12'b0});

    // write-first: a WB write in this cycle is seen by the ID read
    assign rs1_val = (rs1 == '0) ? '0 :
                     (mem_wb_reg_write && mem_wb_rd == rs1) ? mem_wb_data : registers[rs1];
    assign rs2_val = (rs2 == '0) ? '0 :
                     (mem_wb_reg_write && mem_wb_rd == rs2) ? mem_wb_data : registers[rs2];

    logic                  id_reg_write, id_mem_write, id_mem_to_reg, id_alt;
    logic [2:0]            id_f3;
    logic [DATA_WIDTH-1:0] id_a, id_b;

    // address and LUI paths reuse the ALU adder: f3 forced to ADD, LUI adds to zero
    always_comb begin
        id_reg_write  = 1'b0;
        id_mem_write  = 1'b0;
        id_mem_to_reg = 1'b0;
        id_alt        = 1'b0;
        id_f3         = funct3;
        id_a          = rs1_val;
        id_b          = rs2_val;
        case (opcode)
            OP_R: begin
                id_reg_write = 1'b1;
                id_alt       = if_id_instr[30];
            end
            OP_I: begin
                id_reg_write = 1'b1;
                id_alt       = (funct3 == 3'b101) && if_id_instr[30];
                id_b         = imm_i;
            end
            OP_LW: if (funct3 == 3'b010) begin
                id_reg_write  = 1'b1;
                id_mem_to_reg = 1'b1;
                id_f3         = 3'b000;
                id_b          = imm_i;
            end
            OP_SW: if (funct3 == 3'b010) begin
                id_mem_write = 1'b1;
                id_f3        = 3'b000;
                id_b         = imm_s;
            end
            OP_LUI: begin
                id_reg_write = 1'b1;
                id_f3        = 3'b000;
                id_a         = '0;
                id_b         = imm_u;
            end
            default: ;
        endcase
    end

    logic                      id_ex_reg_write, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alt;
    logic [2:0]                id_ex_f3;
    logic [REG_ADDR_WIDTH-1:0] id_ex_rd;
    logic [DATA_WIDTH-1:0]     id_ex_a, id_ex_b, id_ex_store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_alt        <= 1'b0;
            id_ex_f3         <= '0;
            id_ex_rd         <= '0;
            id_ex_a          <= '0;
            id_ex_b          <= '0;
            id_ex_store      <= '0;
        end else begin
            id_ex_reg_write  <= id_reg_write;
            id_ex_mem_write  <= id_mem_write;
            id_ex_mem_to_reg <= id_mem_to_reg;
            id_ex_alt        <= id_alt;
            id_ex_f3         <= id_f3;
            id_ex_rd         <= rd;
            id_ex_a          <= id_a;
            id_ex_b          <= id_b;
            id_ex_store      <= rs2_val;
        end
    end

    // ---------------- EX ----------------
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] ex_res;

    assign shamt = id_ex_b[4:0];

    always_comb begin
        ex_res = '0;
        case (id_ex_f3)
            3'b000: ex_res = id_ex_alt ? id_ex_a - id_ex_b : id_ex_a + id_ex_b;
            3'b001: ex_res = id_ex_a << shamt;
            3'b010: ex_res = DATA_WIDTH'($signed(id_ex_a) < $signed(id_ex_b));
            3'b011: ex_res = DATA_WIDTH'(id_ex_a < id_ex_b);
            3'b100: ex_res = id_ex_a ^ id_ex_b;
            3'b101: ex_res = id_ex_alt ? DATA_WIDTH'($signed(id_ex_a) >>> shamt) : id_ex_a >> shamt;
            3'b110: ex_res = id_ex_a | id_ex_b;
            3'b111: ex_res = id_ex_a & id_ex_b;
            default: ;
        endcase
    end

    logic                      ex_mem_reg_write, ex_mem_mem_write, ex_mem_mem_to_reg;
    logic [REG_ADDR_WIDTH-1:0] ex_mem_rd;
    logic [DATA_WIDTH-1:0]     ex_mem_alu, ex_mem_store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            ex_mem_mem_to_reg <= 1'b0;
            ex_mem_rd         <= '0;
            ex_mem_alu        <= '0;
            ex_mem_store      <= '0;
        end else begin
            ex_mem_reg_write  <= id_ex_reg_write;
            ex_mem_mem_write  <= id_ex_mem_write;
            ex_mem_mem_to_reg <= id_ex_mem_to_reg;
            ex_mem_rd         <= id_ex_rd;
            ex_mem_alu        <= ex_res;
            ex_mem_store      <= id_ex_store;
        end
    end

    // ---------------- MEM ----------------
    logic [DAW-1:0]        dmem_idx;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign dmem_idx  = ex_mem_alu[DAW+1:2];
    assign mem_rdata = data_memory[dmem_idx];

    always_ff @(posedge clk) begin
        if (ex_mem_mem_write) data_memory[dmem_idx] <= ex_mem_store;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_reg_write <= 1'b0;
            mem_wb_rd        <= '0;
            mem_wb_data      <= '0;
        end else begin
            mem_wb_reg_write <= ex_mem_reg_write;
            mem_wb_rd        <= ex_mem_rd;
            mem_wb_data      <= ex_mem_mem_to_reg ? mem_rdata : ex_mem_alu;
        end
    end

    // ---------------- WB ----------------
    always_ff @(posedge clk) begin
        if (mem_wb_reg_write && mem_wb_rd != '0) registers[mem_wb_rd] <= mem_wb_data;
    end

endmodule

// File: tb/tb_rv32i_pipe_core.sv
// Bench for rv32i_pipe_core: directed spec programs plus random programs checked
// against an instruction-at-a-time architectural model.
module tb_rv32i_pipe_core;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic pc_we = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mr [0:31];
    logic [31:0] mm [0:255];
    logic [31:0] prog [$];

    always #5 clk = ~clk;

    rv32i_pipe_core dut (.clk(clk), .rst_n(rst_n), .pc_we(pc_we));

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    // ---------------- architectural reference model ----------------
    function automatic logic [31:0] model_alu(input logic [2:0] f3, input logic alt,
                                              input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic void model_exec(input logic [31:0] ins);
        logic [31:0] a, b, res, immi, imms;
        logic [2:0]  f3;
        logic        wr;
        a    = mr[ins[19:15]];
        b    = mr[ins[24:20]];
        f3   = ins[14:12];
        immi = {{20{ins[31]}}, ins[31:20]};
        imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        wr   = 1'b0;
        res  = '0;
        case (ins[6:0])
            7'h33: begin res = model_alu(f3, ins[30], a, b); wr = 1'b1; end
            7'h13: begin res = model_alu(f3, (f3 == 3'd5) && ins[30], a, immi); wr = 1'b1; end
            7'h03: if (f3 == 3'd2) begin res = mm[int'(((a + immi) / 4) % 256)]; wr = 1'b1; end
            7'h23: if (f3 == 3'd2) mm[int'(((a + imms) / 4) % 256)] = b;
            7'h37: begin res = {ins[31:12], 12'b0}; wr = 1'b1; end
            default: ;
        endcase
        if (wr && ins[11:7] != 5'd0) mr[ins[11:7]] = res;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom);
        case ($urandom_range(0, 5))
            0: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                            rs2, rs1, f3, rd);
            1: begin
                if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
                if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
                return enc_i(imm, rs1, f3, rd, 7'h13);
            end
            2: return enc_i(imm, rs1, 3'd2, rd, 7'h03);
            3: return enc_s(imm, rs2, rs1);
            4: return {20'($urandom), rd, 7'h37};
            default: return ($urandom_range(0, 1) == 1) ? {imm, rs1, f3, rd, 7'h63}
                                                        : enc_i(imm, rs1, 3'd0, rd, 7'h03);
        endcase
    endfunction

    // ---------------- scenario plumbing ----------------
    // Hold reset, load ROM from prog, preload state in DUT and model, release on a negedge.
    task automatic setup(input bit rnd);
        @(negedge clk);
        rst_n = 1'b0;
        pc_we = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : NOP;
        for (int i = 0; i < 32; i++) begin
            mr[i] = (rnd && i != 0) ? $urandom : 32'd0;
        end
        if (!rnd) begin
            mr[1] = 32'd100;
            mr[2] = 32'd50;
        end
        for (int i = 0; i < 256; i++) mm[i] = rnd ? $urandom : 32'd0;
        mm[33] = 32'hDEADBEEF;
        for (int i = 0; i < 32; i++) dut.registers[i] = mr[i];
        for (int i = 0; i < 256; i++) dut.data_memory[i] = mm[i];
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic one_instr(input logic [31:0] ins);
        prog.delete();
        prog.push_back(ins);
        repeat (4) prog.push_back(NOP);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++; if (dut.pc !== 32'd0) begin bad++; $display("FAIL reset_pc: got %h want 0", dut.pc); end
        total++; if (dut.if_id_instr !== NOP) begin bad++; $display("FAIL reset_ifid: got %h want %h", dut.if_id_instr, NOP); end
        total++; if (dut.mem_wb_reg_write !== 1'b0) begin bad++; $display("FAIL reset_regwrite: got %b want 0", dut.mem_wb_reg_write); end
        total++; if (dut.ex_mem_mem_write !== 1'b0) begin bad++; $display("FAIL reset_memwrite: got %b want 0", dut.ex_mem_mem_write); end
    endtask

    task automatic test_directed();
        logic [31:0] ins [4] = '{32'h002081B3, 32'h06408213, 32'h0200A283, 32'h000F5337};
        int          rdn [4] = '{3, 4, 5, 6};
        logic [31:0] exp [4] = '{32'd150, 32'd200, 32'hDEADBEEF, 32'h000F5000};
        for (int k = 0; k < 4; k++) begin
            one_instr(ins[k]);
            setup(1'b0);
            pc_we = 1'b1;
            run(4);
            total++;
            if (dut.registers[rdn[k]] !== 32'd0) begin
                bad++; $display("FAIL early_write_x%0d: got %h want 0", rdn[k], dut.registers[rdn[k]]);
            end
            run(1);
            total++;
            if (dut.registers[rdn[k]] !== exp[k]) begin
                bad++; $display("FAIL instr_x%0d: got %h want %h", rdn[k], dut.registers[rdn[k]], exp[k]);
            end
        end
    endtask

    task automatic test_store();
        one_instr(32'h0220A023);
        setup(1'b0);
        pc_we = 1'b1;
        run(3);
        total++; if (dut.data_memory[33] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_early: got %h want deadbeef", dut.data_memory[33]); end
        run(1);
        total++; if (dut.data_memory[33] !== 32'd50) begin bad++; $display("FAIL sw_mem33: got %h want 50", dut.data_memory[33]); end
        run(4);
        for (int i = 0; i < 32; i++) begin
            total++;
            if (dut.registers[i] !== mr[i]) begin bad++; $display("FAIL sw_reg_x%0d: got %h want %h", i, dut.registers[i], mr[i]); end
        end
    endtask

    task automatic test_hazards();
        // addi x0 discarded; x8 at distance 3 sees x7 through WB bypass; x9 at distance 2 sees stale x7
        prog = '{enc_i(12'd5, 5'd1, 3'd0, 5'd0, 7'h13), enc_i(12'd1, 5'd1, 3'd0, 5'd7, 7'h13), NOP,
                 enc_r(7'h00, 5'd2, 5'd7, 3'd0, 5'd9), enc_r(7'h00, 5'd2, 5'd7, 3'd0, 5'd8), NOP, NOP, NOP, NOP};
        setup(1'b0);
        pc_we = 1'b1;
        run(12);
        total++; if (dut.registers[0] !== 32'd0) begin bad++; $display("FAIL x0_write: got %h want 0", dut.registers[0]); end
        total++; if (dut.registers[7] !== 32'd101) begin bad++; $display("FAIL haz_x7: got %0d want 101", dut.registers[7]); end
        total++; if (dut.registers[8] !== 32'd151) begin bad++; $display("FAIL bypass_x8: got %0d want 151", dut.registers[8]); end
        total++; if (dut.registers[9] !== 32'd50) begin bad++; $display("FAIL stale_x9: got %0d want 50", dut.registers[9]); end
    endtask

    task automatic test_stall();
        prog = '{32'h06408213, NOP, NOP, NOP, enc_i(12'd1, 5'd10, 3'd0, 5'd10, 7'h13),
                 32'h002081B3, NOP, NOP, NOP, NOP};
        setup(1'b0);
        pc_we = 1'b1;
        run(5);
        pc_we = 1'b0;
        run(10);
        total++; if (dut.pc !== 32'd20) begin bad++; $display("FAIL stall_pc: got %0d want 20", dut.pc); end
        total++; if (dut.registers[3] !== 32'd0) begin bad++; $display("FAIL stall_x3: got %0d want 0", dut.registers[3]); end
        total++; if (dut.registers[4] !== 32'd200) begin bad++; $display("FAIL stall_x4: got %0d want 200", dut.registers[4]); end
        total++; if (dut.registers[10] !== 32'd1) begin bad++; $display("FAIL stall_reissue_x10: got %0d want 1", dut.registers[10]); end
        total++; if (dut.data_memory[33] !== 32'hDEADBEEF) begin bad++; $display("FAIL stall_mem: got %h want deadbeef", dut.data_memory[33]); end
        pc_we = 1'b1;
        run(1);
        total++; if (dut.if_id_instr !== 32'h002081B3) begin bad++; $display("FAIL resume_fetch: got %h want 002081b3", dut.if_id_instr); end
        total++; if (dut.pc !== 32'd24) begin bad++; $display("FAIL resume_pc: got %0d want 24", dut.pc); end
        run(4);
        total++; if (dut.registers[3] !== 32'd150) begin bad++; $display("FAIL resume_x3: got %0d want 150", dut.registers[3]); end
        total++; if (dut.registers[10] !== 32'd1) begin bad++; $display("FAIL resume_x10: got %0d want 1", dut.registers[10]); end
    endtask

    task automatic test_reset_mid();
        prog = '{32'h0220A023, 32'h06408213, NOP, NOP, NOP, NOP};
        setup(1'b0);
        pc_we = 1'b1;
        run(4);
        rst_n = 1'b0;
        pc_we = 1'b0;
        #1;
        total++; if (dut.pc !== 32'd0) begin bad++; $display("FAIL midreset_pc: got %h want 0", dut.pc); end
        total++; if (dut.mem_wb_reg_write !== 1'b0) begin bad++; $display("FAIL midreset_wb: got %b want 0", dut.mem_wb_reg_write); end
        @(negedge clk);
        rst_n = 1'b1;
        run(8);
        total++; if (dut.registers[4] !== 32'd0) begin bad++; $display("FAIL midreset_x4: got %0d want 0", dut.registers[4]); end
        total++; if (dut.data_memory[33] !== 32'd50) begin bad++; $display("FAIL midreset_sw: got %h want 50", dut.data_memory[33]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            prog.delete();
            for (int k = 0; k < 10; k++) begin
                prog.push_back(rand_instr());
                repeat (4) prog.push_back(NOP);
            end
            setup(1'b1);
            foreach (prog[k]) model_exec(prog[k]);
            pc_we = 1'b1;
            run(prog.size() + 6);
            for (int i = 0; i < 32; i++) begin
                total++;
                if (dut.registers[i] !== mr[i]) begin
                    bad++; $display("FAIL rand%0d_x%0d: got %h want %h", it, i, dut.registers[i], mr[i]);
                end
            end
            for (int i = 0; i < 256; i++) begin
                total++;
                if (dut.data_memory[i] !== mm[i]) begin
                    bad++; $display("FAIL rand%0d_mem%0d: got %h want %h", it, i, dut.data_memory[i], mm[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_store();
        test_hazards();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
